// File: rtl/ahblite_slave_mux_if.sv
// ahblite_slave_mux_if
// Master-side AHB-Lite data-phase signals seen by the slave multiplexer.
// The "slave" modport is the multiplexer's view of the bus. The "master" modport
// is the view of the bus fabric, which feeds HREADY back from HREADYOUT.
interface ahblite_slave_mux_if;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport slave (
    input  HREADY,
    input  HTRANS,
    output HRDATA,
    output HREADYOUT,
    output HRESP
  );

  modport master (
    output HREADY,
    output HTRANS,
    input  HRDATA,
    input  HREADYOUT,
    input  HRESP
  );
endinterface

// File: rtl/ahblite_slave_mux.sv
// ahblite_slave_mux
// This module is the AHB-Lite data-phase multiplexer for a Cortex-M0 system with
// four slave ports.
// - At every accepted address phase (HREADY=1), it registers the decoder's one-hot
//   port select.
// - During the data phase, it returns the selected slave's HRDATA, HREADYOUT and HRESP.
// - Unmapped NONSEQ/SEQ accesses go to a built-in default slave. That slave answers
//   with the two-cycle ERROR response (ERR1, then ERR2).
//
// Optional build macro: AHB_MUX_TIMEOUT_EN
//   When defined, a 10-bit wait-state counter aborts a stalled slave after
//   TIMEOUT_CYCLES wait cycles. The abort uses the ERROR sequence and sets the
//   sticky TIMEOUT_FLAG. When undefined, slave wait states are unbounded and
//   TIMEOUT_FLAG is tied low.
module ahblite_slave_mux #(
  parameter bit          PORT0_EN       = 1'b1,
  parameter bit          PORT1_EN       = 1'b1,
  parameter bit          PORT2_EN       = 1'b1,
  parameter bit          PORT3_EN       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  ahblite_slave_mux_if.slave        bus,
  input  logic                      P0_HSEL,
  input  logic                      P1_HSEL,
  input  logic                      P2_HSEL,
  input  logic                      P3_HSEL,
  input  logic [31:0]               P0_HRDATA,
  input  logic [31:0]               P1_HRDATA,
  input  logic [31:0]               P2_HRDATA,
  input  logic [31:0]               P3_HRDATA,
  input  logic                      P0_HREADYOUT,
  input  logic                      P1_HREADYOUT,
  input  logic                      P2_HREADYOUT,
  input  logic                      P3_HREADYOUT,
  input  logic                      P0_HRESP,
  input  logic                      P1_HRESP,
  input  logic                      P2_HRESP,
  input  logic                      P3_HRESP,
  output logic                      TIMEOUT_FLAG
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic        dflt_q, dflt_d;

  logic [3:0]  req_s;
  logic [3:0]  onehot_s;
  logic        new_dflt_s;
  logic        timeout_s;

  logic [31:0] slv_hrdata_s;
  logic        slv_hreadyout_s;
  logic        slv_hresp_s;

  logic [31:0] mux_hrdata_s;
  logic        mux_hreadyout_s;
  logic        mux_hresp_s;

  // Fixed-priority one-hot pick: lowest port number wins when the decoder
  // drives several selects at once.
  function automatic logic [3:0] prio_onehot(input logic [3:0] req);
    logic [3:0] res;
    res = 4'b0000;
    if (req[0]) begin
      res = 4'b0001;
    end else if (req[1]) begin
      res = 4'b0010;
    end else if (req[2]) begin
      res = 4'b0100;
    end else if (req[3]) begin
      res = 4'b1000;
    end else begin
      res = 4'b0000;
    end
    return res;
  endfunction

  // Only HTRANS[1] distinguishes an active transfer; bit 0 (SEQ vs NONSEQ,
  // IDLE vs BUSY) does not change how the data phase is routed.
  logic unused_htrans_s;
  assign unused_htrans_s = &{1'b0, bus.HTRANS[0]};

  // A select from a disabled port is masked here, so that access falls into the
  // unmapped (default-slave) path.
  assign req_s = {P3_HSEL & PORT3_EN, P2_HSEL & PORT2_EN,
                  P1_HSEL & PORT1_EN, P0_HSEL & PORT0_EN};

  // Address-phase decode: the winning select and whether this is an unmapped active transfer
  always_comb begin
    onehot_s   = prio_onehot(req_s);
    new_dflt_s = (req_s == 4'b0000) && bus.HTRANS[1];
  end

  // Capture a new select only on accepted address phases; otherwise hold the data-phase owner
  always_comb begin
    sel_d  = sel_q;
    dflt_d = dflt_q;
    if (bus.HREADY) begin
      sel_d  = onehot_s;
      dflt_d = new_dflt_s;
    end else begin
      sel_d  = sel_q;
      dflt_d = dflt_q;
    end
  end

  // Route the registered port's response; no selection gives a zero-wait OKAY
  always_comb begin
    slv_hrdata_s    = 32'h0000_0000;
    slv_hreadyout_s = 1'b1;
    slv_hresp_s     = 1'b0;
    case (sel_q)
      4'b0001: begin
        slv_hrdata_s    = P0_HRDATA;
        slv_hreadyout_s = P0_HREADYOUT;
        slv_hresp_s     = P0_HRESP;
      end
      4'b0010: begin
        slv_hrdata_s    = P1_HRDATA;
        slv_hreadyout_s = P1_HREADYOUT;
        slv_hresp_s     = P1_HRESP;
      end
      4'b0100: begin
        slv_hrdata_s    = P2_HRDATA;
        slv_hreadyout_s = P2_HREADYOUT;
        slv_hresp_s     = P2_HRESP;
      end
      4'b1000: begin
        slv_hrdata_s    = P3_HRDATA;
        slv_hreadyout_s = P3_HREADYOUT;
        slv_hresp_s     = P3_HRESP;
      end
      default: begin
        slv_hrdata_s    = 32'h0000_0000;
        slv_hreadyout_s = 1'b1;
        slv_hresp_s     = 1'b0;
      end
    endcase
  end

`ifdef AHB_MUX_TIMEOUT_EN
  localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT_CYCLES);

  logic [9:0] cnt_q, cnt_d;
  logic       tflag_q, tflag_d;

  // Count stalled data-phase cycles of a real slave and fire the abort when the limit is reached
  always_comb begin
    cnt_d     = cnt_q;
    timeout_s = 1'b0;
    if (bus.HREADY || (state_q != ST_IDLE)) begin
      cnt_d = 10'd0;
    end else if ((sel_q != 4'b0000) && !slv_hreadyout_s) begin
      cnt_d     = cnt_q + 10'd1;
      timeout_s = (cnt_d == TMO_LIMIT);
    end else begin
      cnt_d = cnt_q;
    end
    tflag_d = tflag_q | timeout_s;
  end

  // Wait-state counter and sticky timeout flag; only reset clears the flag
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      cnt_q   <= 10'd0;
      tflag_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
    end
  end

  assign TIMEOUT_FLAG = tflag_q;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = &{1'b0, 10'(TIMEOUT_CYCLES)};
  assign timeout_s    = 1'b0;
  assign TIMEOUT_FLAG = 1'b0;
`endif

  // Default-slave sequencing: IDLE -> ERR1 -> ERR2, chaining straight into ERR1 for back-to-back unmapped
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (timeout_s) begin
          state_d = ST_ERR1;
        end else if (bus.HREADY && new_dflt_s) begin
          state_d = ST_ERR1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        if (bus.HREADY && new_dflt_s) begin
          state_d = ST_ERR1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // While the error sequence runs, the slave is ignored and the default slave drives the bus
  always_comb begin
    mux_hrdata_s    = slv_hrdata_s;
    mux_hreadyout_s = slv_hreadyout_s;
    mux_hresp_s     = slv_hresp_s;
    if (state_q == ST_ERR1) begin
      mux_hrdata_s    = 32'h0000_0000;
      mux_hreadyout_s = 1'b0;
      mux_hresp_s     = 1'b1;
    end else if (state_q == ST_ERR2) begin
      mux_hrdata_s    = 32'h0000_0000;
      mux_hreadyout_s = 1'b1;
      mux_hresp_s     = 1'b1;
    end else begin
      mux_hrdata_s    = slv_hrdata_s;
      mux_hreadyout_s = slv_hreadyout_s;
      mux_hresp_s     = slv_hresp_s;
    end
  end

  assign bus.HRDATA    = mux_hrdata_s;
  assign bus.HREADYOUT = mux_hreadyout_s;
  assign bus.HRESP     = mux_hresp_s;

  // Select/default registers and FSM state; reset drops any transfer in flight at once
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      sel_q   <= 4'b0000;
      dflt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dflt_q  <= dflt_d;
    end
  end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// tb_ahblite_slave_mux
// Directed bench for ahblite_slave_mux.
// - HREADY is fed back from HREADYOUT, as in a single-master AHB-Lite system.
// - A second instance with port 2 disabled covers the masked-select path.
// - The timeout scenario follows AHB_MUX_TIMEOUT_EN.
module tb_ahblite_slave_mux;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [1:0]  htrans;
  logic [3:0]  hsel;
  logic [31:0] hrdata [4];
  logic [3:0]  hreadyout;
  logic [3:0]  hresp;
  logic        tflag1, tflag2;

  int n_cmp = 0;
  int n_bad = 0;

  ahblite_slave_mux_if bus_if ();
  ahblite_slave_mux_if bus2_if ();

  assign bus_if.HTRANS  = htrans;
  assign bus_if.HREADY  = bus_if.HREADYOUT;
  assign bus2_if.HTRANS = htrans;
  assign bus2_if.HREADY = bus2_if.HREADYOUT;

  // {HRDATA, HREADYOUT, HRESP} of each instance
  logic [33:0] out1_s, out2_s;
  assign out1_s = {bus_if.HRDATA, bus_if.HREADYOUT, bus_if.HRESP};
  assign out2_s = {bus2_if.HRDATA, bus2_if.HREADYOUT, bus2_if.HRESP};

  always #5 HCLK = ~HCLK;

  ahblite_slave_mux #(.TIMEOUT_CYCLES(4)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_if),
    .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]),
    .P0_HRDATA(hrdata[0]), .P1_HRDATA(hrdata[1]), .P2_HRDATA(hrdata[2]), .P3_HRDATA(hrdata[3]),
    .P0_HREADYOUT(hreadyout[0]), .P1_HREADYOUT(hreadyout[1]),
    .P2_HREADYOUT(hreadyout[2]), .P3_HREADYOUT(hreadyout[3]),
    .P0_HRESP(hresp[0]), .P1_HRESP(hresp[1]), .P2_HRESP(hresp[2]), .P3_HRESP(hresp[3]),
    .TIMEOUT_FLAG(tflag1)
  );

  ahblite_slave_mux #(.PORT2_EN(1'b0), .TIMEOUT_CYCLES(4)) u_dut_p2off (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus2_if),
    .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]),
    .P0_HRDATA(hrdata[0]), .P1_HRDATA(hrdata[1]), .P2_HRDATA(hrdata[2]), .P3_HRDATA(hrdata[3]),
    .P0_HREADYOUT(hreadyout[0]), .P1_HREADYOUT(hreadyout[1]),
    .P2_HREADYOUT(hreadyout[2]), .P3_HREADYOUT(hreadyout[3]),
    .P0_HRESP(hresp[0]), .P1_HRESP(hresp[1]), .P2_HRESP(hresp[2]), .P3_HRESP(hresp[3]),
    .TIMEOUT_FLAG(tflag2)
  );

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; hsel = 4'b0010; htrans = 2'b10;
    step(); step();
    #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b10}) begin n_bad++; $display("FAIL reset_out: got %h want %h", out1_s, {32'h0, 2'b10}); end
    n_cmp++; if (tflag1 !== 1'b0) begin n_bad++; $display("FAIL reset_flag: got %b want 0", tflag1); end
    hsel = 4'b0000; htrans = 2'b00; HRESETn = 1'b1;
    step();
    #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b10}) begin n_bad++; $display("FAIL post_reset_idle: got %h want %h", out1_s, {32'h0, 2'b10}); end
  endtask

  task automatic test_mapped_read();
    hsel = 4'b0010; htrans = 2'b10;
    step();
    hsel = 4'b0000; htrans = 2'b00; hrdata[1] = 32'hDEADBEEF; hreadyout[1] = 1'b1;
    #1;
    n_cmp++; if (out1_s !== {32'hDEADBEEF, 2'b10}) begin n_bad++; $display("FAIL p1_read: got %h want %h", out1_s, {32'hDEADBEEF, 2'b10}); end
    hresp[1] = 1'b1;
    #1;
    n_cmp++; if (out1_s !== {32'hDEADBEEF, 2'b11}) begin n_bad++; $display("FAIL p1_resp_pass: got %h want %h", out1_s, {32'hDEADBEEF, 2'b11}); end
    hresp[1] = 1'b0;
    step();
    #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b10}) begin n_bad++; $display("FAIL p1_release: got %h want %h", out1_s, {32'h0, 2'b10}); end
  endtask

  task automatic test_unmapped();
    hsel = 4'b0000; htrans = 2'b10;
    step();
    htrans = 2'b00;
    #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b01}) begin n_bad++; $display("FAIL unmapped_err1: got %h want %h", out1_s, {32'h0, 2'b01}); end
    step(); #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b11}) begin n_bad++; $display("FAIL unmapped_err2: got %h want %h", out1_s, {32'h0, 2'b11}); end
    step(); #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b10}) begin n_bad++; $display("FAIL unmapped_done: got %h want %h", out1_s, {32'h0, 2'b10}); end
    htrans = 2'b01;
    step();
    htrans = 2'b00;
    #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b10}) begin n_bad++; $display("FAIL busy_unmapped_okay: got %h want %h", out1_s, {32'h0, 2'b10}); end
    step();
  endtask

  task automatic test_wait_states();
    hsel = 4'b1000; htrans = 2'b10;
    step();
    hsel = 4'b0001; hreadyout[3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (out1_s !== {32'h3333_3333, 2'b00}) begin n_bad++; $display("FAIL p3_wait%0d: got %h want %h", i, out1_s, {32'h3333_3333, 2'b00}); end
      step();
    end
    hreadyout[3] = 1'b1;
    #1;
    n_cmp++; if (out1_s !== {32'h3333_3333, 2'b10}) begin n_bad++; $display("FAIL p3_done: got %h want %h", out1_s, {32'h3333_3333, 2'b10}); end
    step();
    hsel = 4'b0000; htrans = 2'b00;
    #1;
    n_cmp++; if (out1_s !== {32'h0000_A000, 2'b10}) begin n_bad++; $display("FAIL p0_after_wait: got %h want %h", out1_s, {32'h0000_A000, 2'b10}); end
    step();
  endtask

  task automatic test_back_to_back();
    hsel = 4'b0001; htrans = 2'b10;
    step();
    hsel = 4'b0010; htrans = 2'b11;
    #1;
    n_cmp++; if (out1_s !== {32'h0000_A000, 2'b10}) begin n_bad++; $display("FAIL b2b_first: got %h want %h", out1_s, {32'h0000_A000, 2'b10}); end
    step();
    hsel = 4'b0000; htrans = 2'b00;
    #1;
    n_cmp++; if (out1_s !== {32'hDEADBEEF, 2'b10}) begin n_bad++; $display("FAIL b2b_second: got %h want %h", out1_s, {32'hDEADBEEF, 2'b10}); end
    step();
    htrans = 2'b10;
    step(); #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b01}) begin n_bad++; $display("FAIL b2b_err1a: got %h want %h", out1_s, {32'h0, 2'b01}); end
    step(); #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b11}) begin n_bad++; $display("FAIL b2b_err2a: got %h want %h", out1_s, {32'h0, 2'b11}); end
    step();
    htrans = 2'b00;
    #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b01}) begin n_bad++; $display("FAIL b2b_err1b: got %h want %h", out1_s, {32'h0, 2'b01}); end
    step(); #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b11}) begin n_bad++; $display("FAIL b2b_err2b: got %h want %h", out1_s, {32'h0, 2'b11}); end
    step(); #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b10}) begin n_bad++; $display("FAIL b2b_idle: got %h want %h", out1_s, {32'h0, 2'b10}); end
  endtask

  task automatic test_priority_disabled();
    hsel = 4'b0101; htrans = 2'b10;
    step();
    hsel = 4'b1100;
    #1;
    n_cmp++; if (out1_s !== {32'h0000_A000, 2'b10}) begin n_bad++; $display("FAIL prio_p0: got %h want %h", out1_s, {32'h0000_A000, 2'b10}); end
    step();
    hsel = 4'b0100;
    #1;
    n_cmp++; if (out1_s !== {32'h2222_2222, 2'b10}) begin n_bad++; $display("FAIL prio_p2: got %h want %h", out1_s, {32'h2222_2222, 2'b10}); end
    n_cmp++; if (out2_s !== {32'h3333_3333, 2'b10}) begin n_bad++; $display("FAIL p2off_prio_p3: got %h want %h", out2_s, {32'h3333_3333, 2'b10}); end
    step();
    hsel = 4'b0000; htrans = 2'b00;
    #1;
    n_cmp++; if (out1_s !== {32'h2222_2222, 2'b10}) begin n_bad++; $display("FAIL p2_enabled: got %h want %h", out1_s, {32'h2222_2222, 2'b10}); end
    n_cmp++; if (out2_s !== {32'h0, 2'b01}) begin n_bad++; $display("FAIL p2off_err1: got %h want %h", out2_s, {32'h0, 2'b01}); end
    step(); #1;
    n_cmp++; if (out2_s !== {32'h0, 2'b11}) begin n_bad++; $display("FAIL p2off_err2: got %h want %h", out2_s, {32'h0, 2'b11}); end
    step(); #1;
    n_cmp++; if (out2_s !== {32'h0, 2'b10}) begin n_bad++; $display("FAIL p2off_idle: got %h want %h", out2_s, {32'h0, 2'b10}); end
  endtask

  task automatic test_reset_mid_err();
    htrans = 2'b10;
    step();
    htrans = 2'b00;
    #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b01}) begin n_bad++; $display("FAIL rst_mid_err1: got %h want %h", out1_s, {32'h0, 2'b01}); end
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b10}) begin n_bad++; $display("FAIL rst_mid_abandon: got %h want %h", out1_s, {32'h0, 2'b10}); end
    step(); #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b10}) begin n_bad++; $display("FAIL rst_mid_no_residue: got %h want %h", out1_s, {32'h0, 2'b10}); end
  endtask

  task automatic test_timeout();
    hsel = 4'b0100; htrans = 2'b10;
    step();
    hsel = 4'b0000; htrans = 2'b00; hreadyout[2] = 1'b0;
`ifdef AHB_MUX_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (out1_s !== {32'h2222_2222, 2'b00}) begin n_bad++; $display("FAIL tmo_wait%0d: got %h want %h", i, out1_s, {32'h2222_2222, 2'b00}); end
      step();
    end
    #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b01}) begin n_bad++; $display("FAIL tmo_err1: got %h want %h", out1_s, {32'h0, 2'b01}); end
    n_cmp++; if (tflag1 !== 1'b1) begin n_bad++; $display("FAIL tmo_flag_set: got %b want 1", tflag1); end
    step(); #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b11}) begin n_bad++; $display("FAIL tmo_err2: got %h want %h", out1_s, {32'h0, 2'b11}); end
    step(); #1;
    n_cmp++; if (out1_s !== {32'h0, 2'b10}) begin n_bad++; $display("FAIL tmo_idle: got %h want %h", out1_s, {32'h0, 2'b10}); end
    hreadyout[2] = 1'b1;
    step(); step(); #1;
    n_cmp++; if (tflag1 !== 1'b1) begin n_bad++; $display("FAIL tmo_flag_sticky: got %b want 1", tflag1); end
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    #1;
    n_cmp++; if (tflag1 !== 1'b0) begin n_bad++; $display("FAIL tmo_flag_reset: got %b want 0", tflag1); end
`else
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++; if (out1_s !== {32'h2222_2222, 2'b00}) begin n_bad++; $display("FAIL unbounded_wait%0d: got %h want %h", i, out1_s, {32'h2222_2222, 2'b00}); end
      step();
    end
    #1;
    n_cmp++; if (tflag1 !== 1'b0) begin n_bad++; $display("FAIL no_timeout_flag: got %b want 0", tflag1); end
    hreadyout[2] = 1'b1;
    #1;
    n_cmp++; if (out1_s !== {32'h2222_2222, 2'b10}) begin n_bad++; $display("FAIL unbounded_release: got %h want %h", out1_s, {32'h2222_2222, 2'b10}); end
    step(); step();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESETn = 1'b0; htrans = 2'b00; hsel = 4'b0000;
    hrdata[0] = 32'h0000_A000; hrdata[1] = 32'h1111_1111;
    hrdata[2] = 32'h2222_2222; hrdata[3] = 32'h3333_3333;
    hreadyout = 4'b1111; hresp = 4'b0000;
    test_reset();
    test_mapped_read();
    test_unmapped();
    test_wait_states();
    test_back_to_back();
    test_priority_disabled();
    test_reset_mid_err();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahblite_slave_mux.md
Name: ahblite_slave_mux

Overview:
- Data-phase controller that pairs with the system address decoder on the Cortex-M0 AHB-Lite bus.
- Registers the decoder's one-hot port select at each accepted address phase.
- Returns the selected slave's HRDATA/HREADYOUT/HRESP to the master during the data phase.
- Contains a built-in default slave that gives the two-cycle AHB ERROR response to unmapped accesses.
- Sits between the four slaves (RAMCODE, RAMDATA, keyboard, LCD) and the M0 master port.

Parameters:
- PORT0_EN, 1: port 0 present; if 0, P0_HSEL is ignored and the access counts as unmapped.
- PORT1_EN, 1: same for port 1.
- PORT2_EN, 1: same for port 2.
- PORT3_EN, 1: same for port 3.
- TIMEOUT_CYCLES, 255: wait-state limit used only by the optional feature; range 1..1023.

Ports:
- HCLK input 1: bus clock.
- HRESETn input 1: reset, synchronous, active-low.
- HREADY input 1: global ready fed back from HREADYOUT; address phase is accepted when 1.
- HTRANS input 2: master transfer type; bit1=1 means NONSEQ/SEQ.
- P0_HSEL..P3_HSEL input 1 each: decoder selects.
- P0_HRDATA..P3_HRDATA input 32 each: slave read data.
- P0_HREADYOUT..P3_HREADYOUT input 1 each: slave ready.
- P0_HRESP..P3_HRESP input 1 each: slave response (1=ERROR).
- HRDATA output 32: muxed read data to master.
- HREADYOUT output 1: muxed ready.
- HRESP output 1: muxed response.
- TIMEOUT_FLAG output 1: sticky timeout indicator.

Behaviour:
- Reset (HRESETn=0 at rising HCLK): sel_reg=0, dflt=0, state=IDLE, timeout counter=0, TIMEOUT_FLAG=0. Outputs while in reset/IDLE with sel_reg=0: HREADYOUT=1, HRESP=0, HRDATA=0.
- Reset asserted mid-transfer: abandon the transfer immediately at that edge; no residual ERROR cycle.
- Address-phase capture, only on edges where HREADY=1:
  - sel_reg <= one-hot of the enabled selects, priority P0>P1>P2>P3 if the decoder drives several.
  - dflt <= (no enabled select) AND HTRANS[1].
  - When HREADY=0, sel_reg and dflt hold.
- Data phase, sel_reg one-hot on port n: HRDATA=Pn_HRDATA, HREADYOUT=Pn_HREADYOUT, HRESP=Pn_HRESP. This path is combinational from the registered select; no added latency; slave wait states pass through unchanged.
- Data phase, sel_reg=0 and dflt=0 (IDLE/BUSY to unmapped): HREADYOUT=1, HRESP=0, HRDATA=0 (zero-wait OKAY).
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE->ERR1 on an accepted address phase with dflt=1.
  - ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Because HREADY=1 here, the next address phase is captured on this edge. Next state is ERR1 if that capture sets dflt again (back-to-back unmapped), else IDLE.
  - HRDATA=0 in ERR1 and ERR2.
- Back-to-back mapped transfers: a new select is captured on the same edge the previous slave reports HREADYOUT=1; no bubble cycle.
- Port with PORTn_EN=0 whose HSEL fires on NONSEQ: treated as unmapped, giving the ERROR sequence.

Optional Feature:
- Macro AHB_MUX_TIMEOUT_EN.
- Defined:
  - A 10-bit counter increments each cycle that sel_reg is non-zero and the muxed HREADYOUT=0; it clears whenever HREADY=1.
  - When the counter reaches TIMEOUT_CYCLES, the FSM enters ERR1 and the slave's outputs are ignored until ERR2 completes.
  - sel_reg clears on the ERR2 edge unless a new address is captured.
  - TIMEOUT_FLAG sets to 1 and stays set until reset.
- Not defined: no counter; slave wait states are unbounded; TIMEOUT_FLAG is tied 0.

Test Plan:
- Reset, then P1_HSEL=1, HTRANS=2'b10, HREADY=1 for one cycle; next cycle P1_HRDATA=32'hDEADBEEF, P1_HREADYOUT=1 -> HRDATA=32'hDEADBEEF, HREADYOUT=1, HRESP=0 in that cycle.
- Address 0x30000000 (no HSEL), HTRANS=NONSEQ -> cycle+1: HREADYOUT=0, HRESP=1; cycle+2: HREADYOUT=1, HRESP=1; cycle+3: OKAY idle.
- P3 access with P3_HREADYOUT=0 for 3 cycles, then 1, next P0 address presented throughout -> HREADYOUT low 3 cycles; P0 captured on the 4th edge; P0 data returned on the following cycle.
- Two consecutive unmapped NONSEQ transfers -> ERR1, ERR2, ERR1, ERR2 with no IDLE between; HRESP=1 for 4 cycles.
- HRESETn=0 during ERR1 -> next cycle HREADYOUT=1, HRESP=0, state IDLE.
- With AHB_MUX_TIMEOUT_EN and TIMEOUT_CYCLES=4: P2 holds HREADYOUT=0 forever -> ERROR sequence starts after 4 wait cycles; TIMEOUT_FLAG=1 and stays 1 until reset.
